// File: rtl/alu_cmd_seq.sv
// Register-addressed command sequencer that drives a combinational 4-bit ALU and writes its result back.
// Optional ALU-op statistics counter is built when ALU_CMD_SEQ_STATS_EN is defined.
module alu_cmd_seq #(
    parameter int WIDTH = 4,
    parameter int NREG  = 4,
    parameter int AW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_ld,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_zero,
    output logic [7:0]       op_count
);

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE and the command fields must be held until taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rf_q [NREG];
    logic [WIDTH-1:0] rf_d [NREG];
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             wb_zero_q, wb_zero_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
            wb_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
            wb_zero_q  <= wb_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rd_d       = rd_q;
        wb_data_d  = wb_data_q;
        wb_zero_d  = wb_zero_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_ld) begin
                        rf_d[cmd_rd] = cmd_imm;
                        wb_data_d    = cmd_imm;
                        wb_zero_d    = (cmd_imm == '0);
                        state_d      = WB;
                    end else begin
                        // Sources are read here, so the previous writeback is always visible.
                        alu_a_d    = rf_q[cmd_rs1];
                        alu_b_d    = rf_q[cmd_rs2];
                        alu_ctrl_d = cmd_op;
                        rd_d       = cmd_rd;
                        state_d    = EXEC;
                    end
                end
            end
            EXEC: begin
                rf_d[rd_q] = alu_result;
                wb_data_d  = alu_result;
                wb_zero_d  = alu_zero;
                state_d    = WB;
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = (state_q == IDLE);
    assign wb_valid  = (state_q == WB);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign wb_data   = wb_data_q;
    assign wb_zero   = wb_zero_q;

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [7:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == EXEC && op_count_q != 8'hFF) op_count_d = op_count_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_count_q <= '0;
        else        op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU on the DUT's ALU ports, register-file reference model,
// directed scenarios followed by randomized commands.
module tb_alu_cmd_seq;
  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready, cmd_ld;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd, cmd_rs1, cmd_rs2;
  logic [W-1:0] cmd_imm;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [2:0]   alu_ctrl;
  logic         alu_zero, wb_valid, wb_zero;
  logic [W-1:0] wb_data;
  logic [7:0]   op_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  int rf_m [N];
  int ops_m;
  int last_a, last_b, last_op;
  int exp_data;

  alu_cmd_seq #(.WIDTH(W), .NREG(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_zero(wb_zero), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // behavioural ALU: AND, OR, ADD, SUB, SLT; other codes return 0
  function automatic int alu_f(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a + b;
      6: r = a - b;
      7: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return r & ((1 << W) - 1);
  endfunction

  assign alu_result = W'(alu_f(int'(alu_ctrl), int'(alu_a), int'(alu_b)));
  assign alu_zero   = (alu_result == '0);

  function automatic int exp_count();
`ifdef ALU_CMD_SEQ_STATS_EN
    return (ops_m > 255) ? 255 : ops_m;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) rf_m[i] = 0;
    ops_m = 0; last_a = 0; last_b = 0; last_op = 0; exp_data = 0;
  endtask

  // Presents one command (called just after a falling edge), waits for acceptance,
  // then checks the full EXEC/WB timing against the model.
  task automatic issue(input bit ld, input int op, input int rd, input int rs1,
                       input int rs2, input int imm, input bit hold);
    int n = 0;
    cmd_ld = ld; cmd_op = 3'(op); cmd_rd = 2'(rd); cmd_rs1 = 2'(rs1);
    cmd_rs2 = 2'(rs2); cmd_imm = W'(imm); cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    if (ld) begin
      exp_data = imm & ((1 << W) - 1);
      rf_m[rd] = exp_data;
      @(negedge clk);
      chk("ld_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("ld_ready_low", {31'd0, cmd_ready}, 32'd0);
      chk("ld_wb_data", 32'(wb_data), 32'(exp_data));
      chk("ld_wb_zero", {31'd0, wb_zero}, {31'd0, exp_data == 0});
      chk("ld_alu_a_held", 32'(alu_a), 32'(last_a));
      chk("ld_alu_ctrl_held", 32'(alu_ctrl), 32'(last_op));
    end else begin
      last_a = rf_m[rs1]; last_b = rf_m[rs2]; last_op = op;
      exp_data = alu_f(op, last_a, last_b);
      rf_m[rd] = exp_data;
      ops_m++;
      @(negedge clk);
      chk("exec_ready_low", {31'd0, cmd_ready}, 32'd0);
      chk("exec_wb_valid_low", {31'd0, wb_valid}, 32'd0);
      chk("exec_alu_a", 32'(alu_a), 32'(last_a));
      chk("exec_alu_b", 32'(alu_b), 32'(last_b));
      chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(last_op));
      @(negedge clk);
      chk("op_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("op_ready_low", {31'd0, cmd_ready}, 32'd0);
      chk("op_wb_data", 32'(wb_data), 32'(exp_data));
      chk("op_wb_zero", {31'd0, wb_zero}, {31'd0, exp_data == 0});
    end
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_wb_valid_low", {31'd0, wb_valid}, 32'd0);
    chk("idle_wb_data_hold", 32'(wb_data), 32'(exp_data));
    chk("op_count", 32'(op_count), 32'(exp_count()));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops_t [6] = '{0, 1, 2, 6, 7, 3};
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0;
    cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_wb_zero", {31'd0, wb_zero}, 32'd1);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);

    // ADD 3+5
    issue(1, 0, 0, 0, 0, 3, 0);
    issue(1, 0, 1, 0, 0, 5, 0);
    issue(0, 2, 2, 0, 1, 0, 0);
    chk("add_3_5", 32'(exp_data), 32'd8);
    // SUB 6-3, then r1-r1 = 0
    issue(1, 0, 0, 0, 0, 6, 0);
    issue(1, 0, 1, 0, 0, 3, 0);
    issue(0, 6, 2, 0, 1, 0, 0);
    issue(0, 6, 3, 1, 1, 0, 0);
    // wrap ADD 12+5, AND 10&12, OR 10|5
    issue(1, 0, 0, 0, 0, 12, 0);
    issue(1, 0, 1, 0, 0, 5, 0);
    issue(0, 2, 2, 0, 1, 0, 0);
    issue(1, 0, 0, 0, 0, 10, 0);
    issue(1, 0, 1, 0, 0, 12, 0);
    issue(0, 0, 2, 0, 1, 0, 0);
    issue(1, 0, 1, 0, 0, 5, 0);
    issue(0, 1, 3, 0, 1, 0, 0);
    // dependent back-to-back ADDs with cmd_valid held high throughout
    issue(1, 0, 0, 0, 0, 1, 0);
    issue(1, 0, 1, 0, 0, 1, 0);
    issue(0, 2, 0, 0, 1, 0, 1);
    issue(0, 2, 0, 0, 1, 0, 1);
    issue(0, 2, 0, 0, 1, 0, 1);
    cmd_valid = 1'b0;
    chk("dep_final", 32'(exp_data), 32'd4);
    // self-referencing op: rs1 == rs2 == rd
    issue(0, 2, 0, 0, 0, 0, 0);

    // reset during EXEC of ADD into r2 (r2 = 7 beforehand)
    issue(1, 0, 2, 0, 0, 7, 0);
    cmd_ld = 1'b0; cmd_op = 3'd2; cmd_rd = 2'd2; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    end
    chk("abort_op_count", 32'(op_count), 32'd0);
    issue(0, 1, 3, 2, 2, 0, 0);
    chk("abort_r2_zero", 32'(exp_data), 32'd0);
    // 3 ALU ops + 2 loads since reset
    issue(1, 0, 0, 0, 0, 9, 0);
    issue(1, 0, 1, 0, 0, 4, 0);
    issue(0, 6, 2, 0, 1, 0, 0);
    issue(0, 7, 3, 1, 0, 0, 0);
    chk("stats_small", 32'(op_count), 32'(exp_count()));

    // randomized commands
    for (int i = 0; i < 40; i++) begin
      issue($urandom_range(0, 2) == 0, ops_t[$urandom_range(0, 5)], $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 1) == 1);
    end
    cmd_valid = 1'b0;

    // saturation run
    for (int i = 0; i < 300; i++) begin
      issue(0, ops_t[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 0, 1);
    end
    cmd_valid = 1'b0;
    chk("stats_saturate", 32'(op_count), 32'(exp_count()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
